fdiv_seq: RTL
=============

Name: fdiv_seq

Overview:
- Multi-cycle IEEE-754 single-precision divider, y = x1 / x2. It is the inverse operation of the combinational fmul.
- Uses a radix-2 restoring mantissa divider, with a valid/ready handshake on the input side and on the output side.
- Sits beside fmul in the FPU. The core issues to it and holds the result until it is consumed.
- Fixed latency for every operand class, so the issue logic and the bench can count cycles.

Parameters:
- QBITS, 26, quotient bits generated: 24 mantissa bits + guard + round. Sticky comes from the remainder.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- x1  in  32  dividend, sampled on accept
- x2  in  32  divisor, sampled on accept
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- y  out  32  quotient
- ovf  out  1  result overflowed to infinity
- udf  out  1  result underflowed and was flushed to zero
- dz  out  1  divide by zero
- out_valid  out  1  y and the flags are valid
- out_ready  in  1  consumer takes the result

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - y = 0, ovf = 0, udf = 0, dz = 0.
  - Reset asserted mid-operation aborts it. The next cycle is IDLE with no out_valid, and the partial result is discarded.
- FSM states: IDLE, CALC, ROUND, DONE.
  - IDLE: in_ready = 1. If in_valid, latch the operands and go to CALC with cnt = QBITS-1.
  - CALC: one quotient bit per cycle. Decrement cnt; when cnt = 0, go to ROUND.
  - ROUND: normalize, round, and handle special cases. Register y and the flags, then go to DONE.
  - DONE: out_valid = 1. y and the flags are held stable until out_ready = 1, then go to IDLE.
  - in_ready = 0 in CALC, ROUND and DONE. There is no overlap of operations.
- Latency: accept at edge E puts out_valid = 1 in the cycle after edge E+QBITS+1, which is 28 cycles for QBITS = 26. A completion and an accept never happen in the same cycle.
- Operand decode:
  - exp = 0 is treated as zero (denormals are flushed). Mantissa m = {1, frac}, 24 bits.
  - Sign s = s1 ^ s2.
  - Biased exponent e = e1 - e2 + 127, held in 10-bit signed arithmetic.
  - If m1 < m2: shift the partial remainder left by 1 and decrement e, so that the quotient lies in [1, 2).
- CALC step: r' = 2r - m2 if 2r >= m2 (quotient bit = 1), else r' = 2r (quotient bit = 0). The first step uses r = m1 without doubling.
- ROUND:
  - Round to nearest even on q[25:2]: guard = q[1], round bit = q[0], sticky = (r != 0).
  - If rounding carries out of the 24 bits, the mantissa becomes 1.0 and e increments.
- Final exponent and specials (first matching rule wins):
  - Either operand is NaN, or 0/0, or inf/inf: y = 0x7FC00000, all flags 0.
  - x2 = 0 with x1 finite and nonzero: y = {s, 0xFF, 0}, dz = 1.
  - x1 = inf: y = {s, 0xFF, 0}.
  - x1 = 0 or x2 = inf: y = {s, 0, 0}.
  - e >= 255: y = {s, 0xFF, 0}, ovf = 1.
  - e <= 0: y = {s, 0, 0}, udf = 1.
- Flags: valid only while out_valid = 1. They are cleared at the next accept.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> y = 0x40400000, all flags 0, out_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> y = 0x3EAAAAAB (rounds up). Also 0x3F800000 / 0x3F800001 -> y = 0x3F7FFFFE.
- 0x7F000000 / 0x00800000 -> y = 0x7F800000, ovf = 1.
- 0x00800000 / 0x7F000000 -> y = 0x00000000, udf = 1.
- 0xBF800000 / 0x00000000 -> y = 0xFF800000, dz = 1. Also 0x00000000 / 0x00000000 -> y = 0x7FC00000.
- Handshake and reset:
  - Hold out_ready = 0 for 5 cycles in DONE: y stays stable and in_ready = 0 throughout; the result is consumed on the first out_ready = 1.
  - Assert rst at CALC cycle 10: next cycle in_ready = 1 and out_valid = 0; a new 6/2 issue then yields 0x40400000.

Source files
------------

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE-754 single-precision divider, y = x1 / x2.
// Radix-2 restoring mantissa division, RNE rounding, denormals flushed to zero.
module fdiv_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [25:0]         r;
  logic [23:0]         m2;
  logic [QBITS-1:0]    q;
  logic signed [9:0]   e;
  logic                s;
  logic                nan_c, dz_c, inf_c, zero_c;

  // operand decode for the accept cycle
  logic                nan1, nan2, inf1, inf2, zero1, zero2;
  logic [23:0]         m1_in, m2_in;
  logic signed [9:0]   e0;

  // divider step and rounding
  logic [25:0]         t, r_nx;
  logic                ge;
  logic [23:0]         mant;
  logic                rnd_up;
  logic [24:0]         sum;
  logic [22:0]         frac_f;
  logic signed [9:0]   e_f;
  logic [31:0]         y_nx;
  logic                ovf_nx, udf_nx, dz_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Decode operand classes, mantissas and the unnormalised biased exponent
  always_comb begin
    nan1   = (x1[30:23] == 8'hFF) && (x1[22:0] != '0);
    nan2   = (x2[30:23] == 8'hFF) && (x2[22:0] != '0);
    inf1   = (x1[30:23] == 8'hFF) && (x1[22:0] == '0);
    inf2   = (x2[30:23] == 8'hFF) && (x2[22:0] == '0);
    zero1  = (x1[30:23] == 8'h00);
    zero2  = (x2[30:23] == 8'h00);
    m1_in  = {1'b1, x1[22:0]};
    m2_in  = {1'b1, x2[22:0]};
    e0     = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + 10'sd127;
  end

  // One restoring step; the first step compares the initial remainder undoubled
  always_comb begin
    t    = (cnt == CW'(QBITS - 1)) ? r : {r[24:0], 1'b0};
    ge   = (t >= {2'b00, m2});
    r_nx = ge ? (t - {2'b00, m2}) : t;
  end

  // Round to nearest even, then resolve specials and exponent range
  always_comb begin
    mant   = q[QBITS-1 -: 24];
    rnd_up = q[QBITS-25] & (q[QBITS-26] | (r != '0) | mant[0]);
    sum    = {1'b0, mant} + {24'd0, rnd_up};
    if (sum[24]) begin
      frac_f = '0;
      e_f    = e + 10'sd1;
    end else begin
      frac_f = sum[22:0];
      e_f    = e;
    end
    y_nx   = '0;
    ovf_nx = 1'b0;
    udf_nx = 1'b0;
    dz_nx  = 1'b0;
    if (nan_c) begin
      y_nx = 32'h7FC0_0000;
    end else if (dz_c) begin
      y_nx  = {s, 8'hFF, 23'd0};
      dz_nx = 1'b1;
    end else if (inf_c) begin
      y_nx = {s, 8'hFF, 23'd0};
    end else if (zero_c) begin
      y_nx = {s, 31'd0};
    end else if (e_f >= 10'sd255) begin
      y_nx   = {s, 8'hFF, 23'd0};
      ovf_nx = 1'b1;
    end else if (e_f <= 10'sd0) begin
      y_nx   = {s, 31'd0};
      udf_nx = 1'b1;
    end else begin
      y_nx = {s, e_f[7:0], frac_f};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = CALC;
      CALC:  if (cnt == '0) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch, quotient generation, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      r      <= '0;
      m2     <= '0;
      q      <= '0;
      e      <= '0;
      s      <= 1'b0;
      nan_c  <= 1'b0;
      dz_c   <= 1'b0;
      inf_c  <= 1'b0;
      zero_c <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt    <= CW'(QBITS - 1);
          m2     <= m2_in;
          q      <= '0;
          s      <= x1[31] ^ x2[31];
          nan_c  <= nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2);
          dz_c   <= zero2 & ~zero1 & ~inf1;
          inf_c  <= inf1;
          zero_c <= zero1 | inf2;
          // pre-shifting a smaller dividend keeps the quotient in [1, 2)
          if (m1_in < m2_in) begin
            r <= {1'b0, m1_in, 1'b0};
            e <= e0 - 10'sd1;
          end else begin
            r <= {2'b00, m1_in};
            e <= e0;
          end
          y   <= '0;
          ovf <= 1'b0;
          udf <= 1'b0;
          dz  <= 1'b0;
        end
        CALC: begin
          r   <= r_nx;
          q   <= {q[QBITS-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        ROUND: begin
          y   <= y_nx;
          ovf <= ovf_nx;
          udf <= udf_nx;
          dz  <= dz_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
